// File: rtl/neuron_mac_pkg.sv
// rtl/neuron_mac_pkg.sv - shared types and sizing helpers for the neuron multiply-accumulate
// FSM states, accumulator/product widths and the Q-format consistency check.
package neuron_mac_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } mac_state_e;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  // Headroom of clog2(terms) bits means a full vector can never overflow the accumulator.
  function automatic int acc_width(input int width, input int n_taps, input int lanes);
    return 2 * width + $clog2(n_taps * lanes);
  endfunction

  function automatic bit q_format_ok(input int width, input int int_bits, input int frac_bits);
    return (int_bits + frac_bits) == width;
  endfunction

endpackage

// File: rtl/neuron_mac_mul.sv
// rtl/neuron_mac_mul.sv - one lane's registered full-precision signed multiplier
// The product register is the P stage; it only loads on an accepted beat.
module neuron_mac_mul
  import neuron_mac_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [WIDTH-1:0]             w,
  input  logic [WIDTH-1:0]             x,
  output logic [prod_width(WIDTH)-1:0] p
);

  localparam int PW = prod_width(WIDTH);

  logic signed [PW-1:0] w_ext;
  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] prod;

  // Both operands are widened first so the low PW bits carry the exact signed product.
  always_comb begin
    w_ext = {{WIDTH{w[WIDTH-1]}}, w};
    x_ext = {{WIDTH{x[WIDTH-1]}}, x};
    prod  = w_ext * x_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (en) begin
      p <= prod;
    end
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// rtl/neuron_mac_seq.sv - streamed multi-lane dot product with Q-format rescale and range limiting
// Define NEURON_MAC_SAT_EN to saturate out-of-range results; otherwise they wrap.
module neuron_mac_seq
  import neuron_mac_pkg::*;
#(
  parameter int N_TAPS    = 8,
  parameter int LANES     = 1,
  parameter int WIDTH     = 32,
  parameter int INT_BITS  = 12,
  parameter int FRAC_BITS = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*WIDTH-1:0]         w_in,
  input  logic [LANES*WIDTH-1:0]         x_in,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               sum,
  output logic                           ovf,
  output logic [$clog2(N_TAPS+1)-1:0]    beats
);

  localparam int PW    = prod_width(WIDTH);
  localparam int ACC_W = acc_width(WIDTH, N_TAPS, LANES);
  localparam int BW    = $clog2(N_TAPS + 1);

  if (!q_format_ok(WIDTH, INT_BITS, FRAC_BITS)) begin : g_qfmt_err
    $error("neuron_mac_seq: INT_BITS + FRAC_BITS must equal WIDTH");
  end

  mac_state_e state_q, state_d;

  logic [LANES-1:0][PW-1:0] prod;
  logic                     p_valid_q;
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         lane_sum;
  logic [BW-1:0]            cnt_q;
  logic                     accept;
  logic                     term;
  logic                     release_out;

  logic signed [ACC_W-1:0]  shifted;
  logic [ACC_W-WIDTH:0]     hi_bits;
  logic                     ovf_c;
  logic [WIDTH-1:0]         res_c;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    neuron_mac_mul #(.WIDTH(WIDTH)) u_mul (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (accept),
      .w    (w_in[i*WIDTH +: WIDTH]),
      .x    (x_in[i*WIDTH +: WIDTH]),
      .p    (prod[i])
    );
  end

  always_comb begin
    in_ready    = (state_q == ACC);
    out_valid   = (state_q == DONE);
    accept      = in_valid && in_ready;
    term        = accept && (in_last || (cnt_q == BW'(N_TAPS - 1)));
    release_out = (state_q == DONE) && out_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (term) state_d = DRAIN;
      DRAIN:   state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + {{(ACC_W-PW){prod[i][PW-1]}}, prod[i]};
    end
  end

  // In range only when every bit from the result sign upward is a copy of it.
  always_comb begin
    shifted = $signed(acc_q) >>> FRAC_BITS;
    hi_bits = shifted[ACC_W-1:WIDTH-1];
    ovf_c   = !((&hi_bits) || !(|hi_bits));
`ifdef NEURON_MAC_SAT_EN
    if (ovf_c) begin
      res_c = hi_bits[ACC_W-WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_c = shifted[WIDTH-1:0];
    end
`else
    res_c = shifted[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sum       <= '0;
      ovf       <= 1'b0;
      beats     <= '0;
    end else begin
      p_valid_q <= accept;
      if (release_out) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        if (p_valid_q) acc_q <= acc_q + lane_sum;
        if (accept)    cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == ROUND) begin
        sum   <= res_c;
        ovf   <= ovf_c;
        beats <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb/tb_neuron_mac_seq.sv - directed self-checking bench for neuron_mac_seq
// Expected overflow result follows NEURON_MAC_SAT_EN.
module tb_neuron_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] w_in = '0;
  logic [31:0] x_in = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        ovf;
  logic [3:0]  beats;

  int vecs = 0;
  int errs = 0;

  neuron_mac_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w_in     (w_in),
    .x_in     (x_in),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .ovf      (ovf),
    .beats    (beats)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] w, input logic [31:0] x, input logic last);
    in_valid = 1'b1;
    w_in     = w;
    x_in     = x;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] s, input logic o, input logic [3:0] b);
    chk({tag, "_in_ready_low"}, in_ready, 1'b0);
    tick();
    chk({tag, "_valid_k1"}, out_valid, 1'b0);
    tick();
    chk({tag, "_valid_k2"}, out_valid, 1'b1);
    chk({tag, "_sum"}, sum, s);
    chk({tag, "_ovf"}, ovf, o);
    chk({tag, "_beats"}, beats, b);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] ovf_sum;
`ifdef NEURON_MAC_SAT_EN
    ovf_sum = 32'h7FFF_FFFF;
`else
    ovf_sum = 32'h0010_0000;
`endif

    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_beats", beats, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1.0 + 0.5 + 0.75 = 2.25
    beat(32'h0010_0000, 32'h0010_0000, 1'b0);
    beat(32'h0008_0000, 32'h0010_0000, 1'b0);
    beat(32'h000C_0000, 32'h0010_0000, 1'b1);
    expect_result("q_three", 32'h0024_0000, 1'b0, 4'd3);
    handshake("q_three");

    beat(32'hFFF0_0000, 32'h0008_0000, 1'b1);
    expect_result("signed", 32'hFFF8_0000, 1'b0, 4'd1);
    handshake("signed");

    beat(32'h7FF0_0000, 32'h7FF0_0000, 1'b1);
    expect_result("ovf", ovf_sum, 1'b1, 4'd1);
    handshake("ovf");

    for (int i = 0; i < 8; i++) begin
      beat(32'h0010_0000, 32'h0010_0000, 1'b0);
    end
    expect_result("auto8", 32'h0080_0000, 1'b0, 4'd8);

    // Consumer stalls while the producer keeps offering beats that must be ignored.
    in_valid = 1'b1;
    w_in     = 32'h0100_0000;
    x_in     = 32'h0100_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_sum", sum, 32'h0080_0000);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    handshake("stall");
    beat(32'h0010_0000, 32'h0008_0000, 1'b1);
    expect_result("after_stall", 32'h0008_0000, 1'b0, 4'd1);
    handshake("after_stall");

    beat(32'h0010_0000, 32'h0010_0000, 1'b0);
    beat(32'h0010_0000, 32'h0010_0000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_sum", sum, 32'h0);
    chk("midrst_beats", beats, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();
    beat(32'h0010_0000, 32'h0010_0000, 1'b1);
    expect_result("post_rst", 32'h0010_0000, 1'b0, 4'd1);
    handshake("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Clocked, parametrised successor to the combinational `rmac` neuron multiply-accumulate. It accepts a dot-product vector as a stream of beats, each beat carrying `LANES` signed fixed-point weight/input pairs, and accumulates at full precision. After the vector ends it rescales and range-limits the sum to Q`INT_BITS`.`FRAC_BITS`. It sits between the weight/activation fetch logic and the activation-function stage of a neuron, with valid/ready handshakes on both sides.

## Interface
- `N_TAPS`, 8, maximum beats per vector; the vector auto-terminates at this count.
- `LANES`, 1, weight/input pairs per beat.
- `WIDTH`, 32, operand and result width.
- `INT_BITS`, 12, integer bits of the fixed-point format, sign included.
- `FRAC_BITS`, 20, fraction bits; `INT_BITS + FRAC_BITS == WIDTH`, elaboration error otherwise.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  block accepts a beat.
- `w_in`  in  `LANES*WIDTH`  packed signed weights; lane 0 in the LSBs.
- `x_in`  in  `LANES*WIDTH`  packed signed inputs.
- `in_last`  in  1  final beat of the vector.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  `WIDTH`  rescaled dot product.
- `ovf`  out  1  result exceeded the representable range.
- `beats`  out  `clog2(N_TAPS+1)`  beats in this vector.

## Operation
- Beat accepted when `in_valid && in_ready`.
- Per lane: signed product of width 2·`WIDTH`, registered in stage P.
- Accumulator width `ACC_W = 2*WIDTH + clog2(N_TAPS*LANES)`. Stage P products are sign-extended and summed into it, so the accumulator never overflows.
- End of vector: beat accepted with `in_last`, or the `N_TAPS`-th beat, whichever comes first.
- Rescale: `acc >>> FRAC_BITS`, arithmetic shift, truncating toward −∞. Out-of-range handling is set by the Configuration macro. `ovf=1` whenever the rescaled value lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- FSM:
  - `ACC`: `in_ready=1`. On the terminating beat, go to `DRAIN`.
  - `DRAIN`: final product enters the accumulator. Go to `ROUND`.
  - `ROUND`: rescale; load `sum`, `ovf`, `beats`; set `out_valid`. Go to `DONE`.
  - `DONE`: hold the outputs. On `out_ready`: clear the accumulator and beat counter, drop `out_valid`, go to `ACC`.
- `in_ready` is 0 in `DRAIN`, `ROUND` and `DONE`, so there is no overlap between vectors.
- Reset state: `ACC`, accumulator 0, `in_ready=1`, `out_valid=0`, `sum=0`, `ovf=0`, `beats=0`.

## Timing
- Terminating beat accepted at edge k: `out_valid` rises after edge k+2. Latency is 2 cycles.
- `in_ready` falls after edge k and rises the cycle after the output handshake edge.
- `sum`, `ovf`, `beats` are stable while `out_valid && !out_ready`.
- Non-terminating beats may arrive back-to-back, one per cycle.
- `rst_n` asserted at any point, mid-vector or mid-drain, immediately forces all outputs to their reset values. The partial vector is discarded.

## Configuration
- `NEURON_MAC_SAT_EN` defined: out-of-range results saturate to `0x7FFFFFFF` or `0x80000000` (WIDTH=32).
- `NEURON_MAC_SAT_EN` undefined: results wrap, keeping the low `WIDTH` bits of the rescaled value.
- `ovf` reports range overflow in both cases.

## Structure
- Package `neuron_mac_pkg` holds:
  - the FSM state enum (`ACC`, `DRAIN`, `ROUND`, `DONE`);
  - the `acc_width(WIDTH, N_TAPS, LANES)` function;
  - the Q-format check.
- Sub-module `neuron_mac_mul`: one lane's registered signed multiplier, instantiated `LANES` times with a generate loop.

## Test plan
- Q12.20 vector, one beat per pair, `in_last` on the third beat: W/X = 0x00100000/0x00100000, 0x00080000/0x00100000, 0x000C0000/0x00100000 → `sum`=0x00240000 (2.25), `ovf`=0, `beats`=3, `out_valid` 2 cycles after the third beat.
- Signed: W=0xFFF00000 (−1.0), X=0x00080000 (0.5), `in_last` → `sum`=0xFFF80000 (−0.5).
- Overflow: W=X=0x7FF00000 (2047.0), `in_last` → `ovf`=1. `sum`=0x7FFFFFFF with `NEURON_MAC_SAT_EN`, 0x00100000 without.
- Eight beats of 1.0×1.0 with `in_last` never asserted → auto-terminate, `sum`=0x00800000, `beats`=8.
- `out_ready` held low 5 cycles → `sum` held, `in_ready`=0, and `in_valid` beats are ignored; after the handshake the next vector starts from 0.
- `rst_n` pulsed low after 2 of 3 beats → `out_valid`=0 and `in_ready`=1; a fresh 1.0×1.0 vector then yields 0x00100000.
